// File: rtl/axi_gpio_bank.sv
// AXI4 slave GPIO bank: CH_COUNT channels of OUT/IN/DIR registers with burst support.
// Define GPIO_IRQ_EN to build the IRQ_EN/IRQ_STAT registers, edge detector and irq output.
module axi_gpio_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int ID_WIDTH   = 8,
  parameter int CH_COUNT   = 2,
  parameter int GPIO_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ID_WIDTH-1:0]            s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic [7:0]                     s_axi_awlen,
  input  logic [2:0]                     s_axi_awsize,
  input  logic [1:0]                     s_axi_awburst,
  input  logic                           s_axi_awlock,
  input  logic [3:0]                     s_axi_awcache,
  input  logic [2:0]                     s_axi_awprot,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wlast,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [ID_WIDTH-1:0]            s_axi_bid,
  output logic [1:0]                     s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ID_WIDTH-1:0]            s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic [7:0]                     s_axi_arlen,
  input  logic [2:0]                     s_axi_arsize,
  input  logic [1:0]                     s_axi_arburst,
  input  logic                           s_axi_arlock,
  input  logic [3:0]                     s_axi_arcache,
  input  logic [2:0]                     s_axi_arprot,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [ID_WIDTH-1:0]            s_axi_rid,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                     s_axi_rresp,
  output logic                           s_axi_rlast,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  input  logic [CH_COUNT*GPIO_WIDTH-1:0] gpio_in,
  output logic [CH_COUNT*GPIO_WIDTH-1:0] gpio_out,
  output logic [CH_COUNT*GPIO_WIDTH-1:0] gpio_oe,
  output logic                           irq
);

  localparam int CH_W = ADDR_WIDTH - 5;
  localparam int SB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [GPIO_WIDTH-1:0] out_r   [CH_COUNT];
  logic [GPIO_WIDTH-1:0] dir_r   [CH_COUNT];
  logic [GPIO_WIDTH-1:0] in_p0   [CH_COUNT];
  logic [GPIO_WIDTH-1:0] in_p1   [CH_COUNT];
`ifdef GPIO_IRQ_EN
  logic [GPIO_WIDTH-1:0] in_p2   [CH_COUNT];
  logic [GPIO_WIDTH-1:0] irq_en_r[CH_COUNT];
  logic [GPIO_WIDTH-1:0] stat_r  [CH_COUNT];
  logic                  any_stat;
`endif
  logic                  irq_q;

  function automatic logic is_unmapped(input logic [ADDR_WIDTH-1:0] a);
    logic bad;
    bad = (a[ADDR_WIDTH-1:5] >= CH_W'(CH_COUNT)) || (a[4:2] > 3'd4);
`ifndef GPIO_IRQ_EN
    bad = bad || (a[4:2] == 3'd3) || (a[4:2] == 3'd4);
`endif
    return bad;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [1:0] burst);
    return (burst == 2'b00) ? a : a + ADDR_WIDTH'(4);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] strb_mask(input logic [SB_W-1:0] s);
    logic [DATA_WIDTH-1:0] m;
    for (int b = 0; b < SB_W; b++) m[8*b +: 8] = {8{s[b]}};
    return m;
  endfunction

  function automatic logic [GPIO_WIDTH-1:0] merge(input logic [GPIO_WIDTH-1:0] old,
                                                  input logic [DATA_WIDTH-1:0] d,
                                                  input logic [SB_W-1:0] s);
    logic [DATA_WIDTH-1:0] m, full;
    m    = strb_mask(s);
    full = (DATA_WIDTH'(old) & ~m) | (d & m);
    return full[GPIO_WIDTH-1:0];
  endfunction

  // Unmapped offsets and out-of-range channels fall through to zero.
  function automatic logic [DATA_WIDTH-1:0] rd_word(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    for (int c = 0; c < CH_COUNT; c++) begin
      if (a[ADDR_WIDTH-1:5] == CH_W'(c)) begin
        case (a[4:2])
          3'd0:    v = DATA_WIDTH'(out_r[c]);
          3'd1:    v = DATA_WIDTH'(in_p1[c]);
          3'd2:    v = DATA_WIDTH'(dir_r[c]);
`ifdef GPIO_IRQ_EN
          3'd3:    v = DATA_WIDTH'(irq_en_r[c]);
          3'd4:    v = DATA_WIDTH'(stat_r[c]);
`endif
          default: v = '0;
        endcase
      end
    end
    return v;
  endfunction

  // ---------------- write channel ----------------
  w_state_t              w_state, w_next;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_cnt;
  logic [1:0]            w_burst;
  logic                  w_err;
  logic                  w_fire, w_bad;
  logic [CH_COUNT-1:0]   wr_sel;

  assign w_fire = (w_state == W_DATA) && s_axi_wvalid;
  assign w_bad  = is_unmapped(w_addr);

  always_comb begin
    wr_sel = '0;
    for (int c = 0; c < CH_COUNT; c++)
      wr_sel[c] = w_fire && !w_bad && (w_addr[ADDR_WIDTH-1:5] == CH_W'(c));
  end

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (s_axi_awvalid) w_next = W_DATA;
      W_DATA:  if (w_fire && (w_cnt == w_len)) w_next = W_RESP;
      W_RESP:  if (s_axi_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = (w_state == W_IDLE);
    s_axi_wready  = (w_state == W_DATA);
    s_axi_bvalid  = (w_state == W_RESP);
    s_axi_bresp   = {w_err, 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_addr    <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_burst   <= '0;
      w_err     <= 1'b0;
      s_axi_bid <= '0;
    end else if (w_state == W_IDLE && s_axi_awvalid) begin
      w_addr    <= s_axi_awaddr;
      w_len     <= s_axi_awlen;
      w_cnt     <= '0;
      w_burst   <= s_axi_awburst;
      w_err     <= 1'b0;
      s_axi_bid <= s_axi_awid;
    end else if (w_fire) begin
      w_err  <= w_err | w_bad;
      w_addr <= next_addr(w_addr, w_burst);
      w_cnt  <= w_cnt + 8'd1;
    end
  end

  // ---------------- register file and pad sync ----------------
  always_ff @(posedge clk) begin
    for (int c = 0; c < CH_COUNT; c++) begin
      if (rst) begin
        out_r[c]    <= '0;
        dir_r[c]    <= '0;
        in_p0[c]    <= '0;
        in_p1[c]    <= '0;
`ifdef GPIO_IRQ_EN
        in_p2[c]    <= '0;
        irq_en_r[c] <= '0;
        stat_r[c]   <= '0;
`endif
      end else begin
        in_p0[c] <= gpio_in[c*GPIO_WIDTH +: GPIO_WIDTH];
        in_p1[c] <= in_p0[c];
        if (wr_sel[c] && w_addr[4:2] == 3'd0) out_r[c] <= merge(out_r[c], s_axi_wdata, s_axi_wstrb);
        if (wr_sel[c] && w_addr[4:2] == 3'd2) dir_r[c] <= merge(dir_r[c], s_axi_wdata, s_axi_wstrb);
`ifdef GPIO_IRQ_EN
        in_p2[c] <= in_p1[c];
        if (wr_sel[c] && w_addr[4:2] == 3'd3)
          irq_en_r[c] <= merge(irq_en_r[c], s_axi_wdata, s_axi_wstrb);
        // A fresh edge outranks a simultaneous W1C of the same bit.
        stat_r[c] <= (stat_r[c] & ~((wr_sel[c] && w_addr[4:2] == 3'd4) ?
                                    merge('0, s_axi_wdata, s_axi_wstrb) : '0))
                   | (in_p1[c] & ~in_p2[c] & irq_en_r[c]);
`endif
      end
    end
  end

`ifdef GPIO_IRQ_EN
  always_comb begin
    any_stat = 1'b0;
    for (int c = 0; c < CH_COUNT; c++) any_stat = any_stat | (|stat_r[c]);
  end

  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= any_stat;
  end
`else
  assign irq_q = 1'b0;
`endif

  assign irq = irq_q;

  for (genvar g = 0; g < CH_COUNT; g++) begin : g_pins
    assign gpio_out[g*GPIO_WIDTH +: GPIO_WIDTH] = out_r[g];
    assign gpio_oe [g*GPIO_WIDTH +: GPIO_WIDTH] = dir_r[g];
  end

  // ---------------- read channel ----------------
  r_state_t              r_state, r_next;
  logic [ADDR_WIDTH-1:0] r_addr, r_addr_nx;
  logic [7:0]            r_len, r_cnt;
  logic [1:0]            r_burst;

  assign r_addr_nx = next_addr(r_addr, r_burst);

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (s_axi_arvalid) r_next = R_DATA;
      R_DATA:  if (s_axi_rready && s_axi_rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = (r_state == R_IDLE);
    s_axi_rvalid  = (r_state == R_DATA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_burst     <= '0;
      s_axi_rid   <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= '0;
      s_axi_rlast <= 1'b0;
    end else if (r_state == R_IDLE && s_axi_arvalid) begin
      r_addr      <= s_axi_araddr;
      r_len       <= s_axi_arlen;
      r_cnt       <= '0;
      r_burst     <= s_axi_arburst;
      s_axi_rid   <= s_axi_arid;
      s_axi_rdata <= rd_word(s_axi_araddr);
      s_axi_rresp <= {is_unmapped(s_axi_araddr), 1'b0};
      s_axi_rlast <= (s_axi_arlen == 8'd0);
    end else if (r_state == R_DATA && s_axi_rready) begin
      if (s_axi_rlast) begin
        s_axi_rlast <= 1'b0;
      end else begin
        r_addr      <= r_addr_nx;
        r_cnt       <= r_cnt + 8'd1;
        s_axi_rdata <= rd_word(r_addr_nx);
        s_axi_rresp <= {is_unmapped(r_addr_nx), 1'b0};
        s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                       s_axi_arsize, s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_wlast};

endmodule
